operand_fetch: RTL and testbench
================================

# operand_fetch

Register-read pipeline stage sitting directly in front of the 32x32 `regfile`, between decode and execute. It accepts decoded instructions over a valid/ready handshake and drives the regfile read addresses. It captures both source operands, with write-port forwarding, and presents them to execute through a 2-entry skid buffer. Held entries snoop the writeback port, so buffered operands never go stale.

## Interface
- No parameters. Data width is fixed at 32 and register address width at 5, matching `regfile`.
- `Clk  in  1`: clock; all state updates on the positive edge.
- `Reset  in  1`: asynchronous, active-high reset.
- `InValid  in  1`: decode has an instruction.
- `InReady  out  1`: stage can accept this cycle.
- `InRs  in  5`: source register A.
- `InRt  in  5`: source register B.
- `InDest  in  5`: destination register, passed through.
- `ReadRegister1  out  5`: to regfile; combinational copy of `InRs`.
- `ReadRegister2  out  5`: to regfile; combinational copy of `InRt`.
- `ReadData1  in  32`: from regfile, port 1.
- `ReadData2  in  32`: from regfile, port 2.
- `WbRegWrite  in  1`: the same signal that drives regfile `RegWrite`.
- `WbRegister  in  5`: the same signal that drives regfile `WriteRegister`.
- `WbData  in  32`: the same signal that drives regfile `WriteData`.
- `OutValid  out  1`: operand bundle available.
- `OutReady  in  1`: execute consumes the bundle.
- `OutOperandA  out  32`: operand A.
- `OutOperandB  out  32`: operand B.
- `OutDest  out  5`: destination register.

## Operation
- Accept fires when `InValid && InReady` at a rising edge. Pop fires when `OutValid && OutReady`.
- Storage is a head entry, which drives the `Out*` ports, plus a skid entry. Each entry holds opA, opB, rs, rt and dest.
- Occupancy states: EMPTY, ONE, FULL.
  - EMPTY: accept -> ONE.
  - ONE: accept with no pop -> FULL, new entry into skid. Pop with no accept -> EMPTY. Accept and pop together -> ONE, new entry into head.
  - FULL: pop -> ONE, skid moves to head. Accept is impossible because `InReady`=0.
- Operand capture, per source with `s` = rs or rt:
  - `s`==0 -> 0, regardless of `ReadData` or `WbData`.
  - `WbRegWrite && WbRegister==s && s!=0` -> `WbData` (bypass, see Configuration).
  - Otherwise -> `ReadData1` / `ReadData2`.
- Snoop of held entries: on every edge, every valid entry whose rs or rt is nonzero and equals `WbRegister` while `WbRegWrite`=1 has that operand overwritten with `WbData`.
  - Snoop applies even when `OutValid && !OutReady`. This is the only permitted change to a stalled head.
  - An entry moving from skid to head on the same edge carries its snooped value.
- `OutValid` = (state != EMPTY). `OutDest` is never modified after capture.

## Timing
- Reset values: state=EMPTY; `OutValid`=0; `OutOperandA`=0, `OutOperandB`=0, `OutDest`=0; skid contents 0; `InReady`=1 unless the hazard term applies.
- Latency: accepted at edge N -> `OutValid`=1 and operands valid immediately after edge N.
- Throughput is one instruction per cycle when `OutReady` is held high.
- `InReady` = (state != FULL) && !hazard. Hazard is 0 with bypass; see Configuration for the non-bypass case.
- `ReadRegister1` and `ReadRegister2` are purely combinational from `InRs` and `InRt`, with zero latency.
- Reset asserted mid-operation discards all entries asynchronously. Outputs return to their reset values without waiting for a clock edge.
- A write to register 0 never bypasses and never snoops.

## Configuration
- `OPERAND_FETCH_BYPASS_EN` defined:
  - Same-edge forwarding from `WbData` at capture, as described in Operation.
  - hazard = 0.
- Macro not defined:
  - No forwarding at capture.
  - hazard = `WbRegWrite && WbRegister!=0 && (WbRegister==InRs || WbRegister==InRt)`.
  - The stage stalls `InReady` for that cycle. It then reads the regfile's updated value on the next cycle.
  - Snoop of held entries remains enabled in both builds.

## Test plan
- Reset mid-stream:
  - Stimulus: fill to FULL, assert `Reset` between edges.
  - Required: `OutValid`=0, `OutOperandA`=0, and `InReady`=1 immediately.
- Basic path:
  - Stimulus: regfile r2=42, r5=7; accept rs=2, rt=5, dest=9.
  - Required: next cycle `OutOperandA`=42, `OutOperandB`=7, `OutDest`=9, `OutValid`=1.
- Capture-edge bypass:
  - Stimulus: accept rs=3 while `WbRegWrite`=1, `WbRegister`=3, `WbData`=15.
  - Required with macro: `OutOperandA`=15.
  - Required without macro: `InReady`=0 that cycle; a retry on the next cycle captures 15.
- Register 0:
  - Stimulus: accept rs=0, rt=0 while the writeback targets r0 with 99 and `ReadData` is forced to 0xFFFFFFFF.
  - Required: both operands 0.
- Skid and back-pressure:
  - Stimulus: hold `OutReady`=0 and accept two instructions (A then B).
  - Required: `InReady`=0 after the second accept; the head stays A.
  - Then raise `OutReady`: A pops, then B pops, one per cycle, in order, with no drop or duplicate.
- Snoop of stalled entry:
  - Stimulus: head holds rt=4 with operand 10 and `OutReady`=0; writeback r4=77.
  - Required: `OutOperandB`=77 on the next cycle.
  - Also: writeback to r6, which is not a source of any held entry, changes nothing.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage between decode and execute.
// Drives the regfile read addresses, captures both source operands and
// presents them to execute through a head entry plus a skid entry.
// Held entries snoop the writeback port so buffered operands stay current.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready within this stage, and a stalled
// head changes only through writeback snooping.
//
// Optional feature macro: OPERAND_FETCH_BYPASS_EN
//   defined   -> WbData is forwarded at capture, InReady never hazard-stalls
//   undefined -> no capture forwarding; InReady drops for one cycle when the
//                writeback targets a source being presented, and the
//                regfile's updated value is read on the following cycle
module operand_fetch (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        InValid,
   output logic        InReady,
   input  logic [4:0]  InRs,
   input  logic [4:0]  InRt,
   input  logic [4:0]  InDest,
   output logic [4:0]  ReadRegister1,
   output logic [4:0]  ReadRegister2,
   input  logic [31:0] ReadData1,
   input  logic [31:0] ReadData2,
   input  logic        WbRegWrite,
   input  logic [4:0]  WbRegister,
   input  logic [31:0] WbData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] OutOperandA,
   output logic [31:0] OutOperandB,
   output logic [4:0]  OutDest,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t      r_state;

   // head entry drives the Out* ports directly
   logic [31:0] r_head_a;
   logic [31:0] r_head_b;
   logic [4:0]  r_head_rs;
   logic [4:0]  r_head_rt;
   logic [4:0]  r_head_dest;
   logic        r_out_valid;

   // skid entry, only meaningful in ST_FULL
   logic [31:0] r_skid_a;
   logic [31:0] r_skid_b;
   logic [4:0]  r_skid_rs;
   logic [4:0]  r_skid_rt;
   logic [4:0]  r_skid_dest;

   logic        w_hazard;
   logic        w_accept;
   logic        w_pop;
   logic [31:0] w_cap_a;
   logic [31:0] w_cap_b;
   logic [31:0] w_head_a_sn;
   logic [31:0] w_head_b_sn;
   logic [31:0] w_skid_a_sn;
   logic [31:0] w_skid_b_sn;

   // a held operand is replaced when the writeback targets its nonzero source
   function automatic logic [31:0] f_snoop(input logic [4:0] src,
                                           input logic [31:0] op,
                                           input logic        wb_we,
                                           input logic [4:0]  wb_reg,
                                           input logic [31:0] wb_data);
      if (wb_we && (wb_reg != 5'd0) && (wb_reg == src))
         f_snoop = wb_data;
      else
         f_snoop = op;
   endfunction

   // capture value for one source: r0 reads as zero, optional forwarding
   function automatic logic [31:0] f_capture(input logic [4:0]  src,
                                             input logic [31:0] rd_data,
                                             input logic        wb_we,
                                             input logic [4:0]  wb_reg,
                                             input logic [31:0] wb_data);
      if (src == 5'd0)
         f_capture = 32'd0;
`ifdef OPERAND_FETCH_BYPASS_EN
      else if (wb_we && (wb_reg == src))
         f_capture = wb_data;
`endif
      else
         f_capture = rd_data;
   endfunction

   // read addresses pass straight through to the regfile
   assign ReadRegister1 = InRs;
   assign ReadRegister2 = InRt;

   // hazard stalls intake only when capture cannot forward the writeback
`ifdef OPERAND_FETCH_BYPASS_EN
   assign w_hazard = 1'b0;
`else
   assign w_hazard = WbRegWrite && (WbRegister != 5'd0) &&
                     ((WbRegister == InRs) || (WbRegister == InRt));
`endif

   assign InReady  = (r_state != ST_FULL) && !w_hazard;
   assign w_accept = InValid && InReady;
   assign w_pop    = r_out_valid && OutReady;

   assign w_cap_a  = f_capture(InRs, ReadData1, WbRegWrite, WbRegister, WbData);
   assign w_cap_b  = f_capture(InRt, ReadData2, WbRegWrite, WbRegister, WbData);

   assign w_head_a_sn = f_snoop(r_head_rs, r_head_a, WbRegWrite, WbRegister, WbData);
   assign w_head_b_sn = f_snoop(r_head_rt, r_head_b, WbRegWrite, WbRegister, WbData);
   assign w_skid_a_sn = f_snoop(r_skid_rs, r_skid_a, WbRegWrite, WbRegister, WbData);
   assign w_skid_b_sn = f_snoop(r_skid_rt, r_skid_b, WbRegWrite, WbRegister, WbData);

   assign OutValid    = r_out_valid;
   assign OutOperandA = r_head_a;
   assign OutOperandB = r_head_b;
   assign OutDest     = r_head_dest;
   assign o_dbg_state = r_state;

   // occupancy FSM with head/skid storage and writeback snooping
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_head_a    <= 32'd0;
         r_head_b    <= 32'd0;
         r_head_rs   <= 5'd0;
         r_head_rt   <= 5'd0;
         r_head_dest <= 5'd0;
         r_skid_a    <= 32'd0;
         r_skid_b    <= 32'd0;
         r_skid_rs   <= 5'd0;
         r_skid_rt   <= 5'd0;
         r_skid_dest <= 5'd0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_head_a    <= w_cap_a;
                  r_head_b    <= w_cap_b;
                  r_head_rs   <= InRs;
                  r_head_rt   <= InRt;
                  r_head_dest <= InDest;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept) begin
                  if (w_pop) begin
                     // head leaves, new entry takes its place
                     r_head_a    <= w_cap_a;
                     r_head_b    <= w_cap_b;
                     r_head_rs   <= InRs;
                     r_head_rt   <= InRt;
                     r_head_dest <= InDest;
                  end else begin
                     // head stalls (snooped), new entry lands in skid
                     r_head_a    <= w_head_a_sn;
                     r_head_b    <= w_head_b_sn;
                     r_skid_a    <= w_cap_a;
                     r_skid_b    <= w_cap_b;
                     r_skid_rs   <= InRs;
                     r_skid_rt   <= InRt;
                     r_skid_dest <= InDest;
                     r_state     <= ST_FULL;
                  end
               end else if (w_pop) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end else begin
                  r_head_a <= w_head_a_sn;
                  r_head_b <= w_head_b_sn;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  // skid promotes to head carrying its snooped operands
                  r_head_a    <= w_skid_a_sn;
                  r_head_b    <= w_skid_b_sn;
                  r_head_rs   <= r_skid_rs;
                  r_head_rt   <= r_skid_rt;
                  r_head_dest <= r_skid_dest;
                  r_state     <= ST_ONE;
               end else begin
                  r_head_a <= w_head_a_sn;
                  r_head_b <= w_head_b_sn;
                  r_skid_a <= w_skid_a_sn;
                  r_skid_b <= w_skid_b_sn;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small regfile model on the
// read/write ports. Expected values are hand-computed constants.
module tb_operand_fetch;

   logic        Clk;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [4:0]  InRs;
   logic [4:0]  InRt;
   logic [4:0]  InDest;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        WbRegWrite;
   logic [4:0]  WbRegister;
   logic [31:0] WbData;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutOperandA;
   logic [31:0] OutOperandB;
   logic [4:0]  OutDest;
   logic [1:0]  dbg_state;

   int checks;
   int failures;

   logic [31:0] rf [32];
   logic        force_ones;

   operand_fetch dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .InValid       (InValid),
      .InReady       (InReady),
      .InRs          (InRs),
      .InRt          (InRt),
      .InDest        (InDest),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .WbRegWrite    (WbRegWrite),
      .WbRegister    (WbRegister),
      .WbData        (WbData),
      .OutValid      (OutValid),
      .OutReady      (OutReady),
      .OutOperandA   (OutOperandA),
      .OutOperandB   (OutOperandB),
      .OutDest       (OutDest),
      .o_dbg_state   (dbg_state)
   );

   // clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // regfile model: preloaded under reset, written by the writeback port
   always @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
         rf[2] <= 32'd42;
         rf[4] <= 32'd10;
         rf[5] <= 32'd7;
      end else if (WbRegWrite && (WbRegister != 5'd0)) begin
         rf[WbRegister] <= WbData;
      end
   end

   assign ReadData1 = force_ones ? 32'hFFFF_FFFF : rf[ReadRegister1];
   assign ReadData2 = force_ones ? 32'hFFFF_FFFF : rf[ReadRegister2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one edge and sample 1 time unit later
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] dest);
      InValid = v;
      InRs    = rs;
      InRt    = rt;
      InDest  = dest;
   endtask

   task automatic drive_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
      WbRegWrite = we;
      WbRegister = r;
      WbData     = d;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      force_ones = 1'b0;
      Reset      = 1'b1;
      OutReady   = 1'b0;
      drive_in(1'b0, 5'd0, 5'd0, 5'd0);
      drive_wb(1'b0, 5'd0, 32'd0);
      #1;
      check("rst_valid", {31'd0, OutValid}, 32'd0);
      check("rst_ready", {31'd0, InReady}, 32'd1);
      check("rst_opa", OutOperandA, 32'd0);
      check("rst_opb", OutOperandB, 32'd0);
      check("rst_dest", {27'd0, OutDest}, 32'd0);
      step();
      step();
      Reset = 1'b0;
      step();

      // basic path
      OutReady = 1'b1;
      drive_in(1'b1, 5'd2, 5'd5, 5'd9);
      #1;
      check("rdreg1_comb", {27'd0, ReadRegister1}, 32'd2);
      check("rdreg2_comb", {27'd0, ReadRegister2}, 32'd5);
      check("basic_inready", {31'd0, InReady}, 32'd1);
      step();
      drive_in(1'b0, 5'd0, 5'd0, 5'd0);
      check("basic_valid", {31'd0, OutValid}, 32'd1);
      check("basic_opa", OutOperandA, 32'd42);
      check("basic_opb", OutOperandB, 32'd7);
      check("basic_dest", {27'd0, OutDest}, 32'd9);
      step();
      check("basic_popped", {31'd0, OutValid}, 32'd0);

      // capture-edge bypass (r3 holds 0 in the regfile before this write)
      drive_wb(1'b1, 5'd3, 32'd15);
      drive_in(1'b1, 5'd3, 5'd0, 5'd1);
      #1;
`ifdef OPERAND_FETCH_BYPASS_EN
      check("byp_inready", {31'd0, InReady}, 32'd1);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
      drive_in(1'b0, 5'd0, 5'd0, 5'd0);
      check("byp_valid", {31'd0, OutValid}, 32'd1);
      check("byp_opa", OutOperandA, 32'd15);
`else
      check("haz_inready", {31'd0, InReady}, 32'd0);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
      #1;
      check("haz_noaccept", {31'd0, OutValid}, 32'd0);
      check("haz_retry_ready", {31'd0, InReady}, 32'd1);
      step();
      drive_in(1'b0, 5'd0, 5'd0, 5'd0);
      check("haz_valid", {31'd0, OutValid}, 32'd1);
      check("haz_opa", OutOperandA, 32'd15);
`endif
      check("byp_opb_r0", OutOperandB, 32'd0);
      step();
      check("byp_popped", {31'd0, OutValid}, 32'd0);

      // register 0 never forwards and always reads zero
      force_ones = 1'b1;
      drive_wb(1'b1, 5'd0, 32'd99);
      drive_in(1'b1, 5'd0, 5'd0, 5'd2);
      #1;
      check("r0_inready", {31'd0, InReady}, 32'd1);
      step();
      drive_in(1'b0, 5'd0, 5'd0, 5'd0);
      check("r0_opa", OutOperandA, 32'd0);
      check("r0_opb", OutOperandB, 32'd0);
      force_ones = 1'b0;
      drive_wb(1'b0, 5'd0, 32'd0);
      step();
      check("r0_popped", {31'd0, OutValid}, 32'd0);

      // skid and back-pressure
      OutReady = 1'b0;
      drive_in(1'b1, 5'd2, 5'd5, 5'd11);
      step();
      check("skid_a_valid", {31'd0, OutValid}, 32'd1);
      check("skid_a_ready", {31'd0, InReady}, 32'd1);
      drive_in(1'b1, 5'd5, 5'd2, 5'd12);
      step();
      drive_in(1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      check("skid_full_ready", {31'd0, InReady}, 32'd0);
      check("skid_head_dest", {27'd0, OutDest}, 32'd11);
      check("skid_head_opa", OutOperandA, 32'd42);
      step();
      check("skid_stall_dest", {27'd0, OutDest}, 32'd11);
      OutReady = 1'b1;
      step();
      check("skid_b_valid", {31'd0, OutValid}, 32'd1);
      check("skid_b_dest", {27'd0, OutDest}, 32'd12);
      check("skid_b_opa", OutOperandA, 32'd7);
      check("skid_b_opb", OutOperandB, 32'd42);
      check("skid_b_ready", {31'd0, InReady}, 32'd1);
      step();
      check("skid_drained", {31'd0, OutValid}, 32'd0);

      // snoop of a stalled head
      OutReady = 1'b0;
      drive_in(1'b1, 5'd2, 5'd4, 5'd13);
      step();
      drive_in(1'b0, 5'd0, 5'd0, 5'd0);
      check("snoop_pre_opb", OutOperandB, 32'd10);
      drive_wb(1'b1, 5'd4, 32'd77);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
      check("snoop_opb", OutOperandB, 32'd77);
      check("snoop_opa", OutOperandA, 32'd42);
      check("snoop_dest", {27'd0, OutDest}, 32'd13);
      drive_wb(1'b1, 5'd6, 32'd55);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
      check("nosnoop_opa", OutOperandA, 32'd42);
      check("nosnoop_opb", OutOperandB, 32'd77);

      // snoop of the skid entry on the same edge it promotes to head
      drive_in(1'b1, 5'd7, 5'd0, 5'd14);
      step();
      drive_in(1'b0, 5'd0, 5'd0, 5'd0);
      check("promo_full", {31'd0, InReady}, 32'd0);
      drive_wb(1'b1, 5'd7, 32'd88);
      OutReady = 1'b1;
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
      check("promo_dest", {27'd0, OutDest}, 32'd14);
      check("promo_opa", OutOperandA, 32'd88);
      check("promo_opb", OutOperandB, 32'd0);
      step();
      check("promo_drained", {31'd0, OutValid}, 32'd0);

      // reset mid-stream, asserted between edges
      OutReady = 1'b0;
      drive_in(1'b1, 5'd2, 5'd5, 5'd3);
      step();
      drive_in(1'b1, 5'd5, 5'd2, 5'd4);
      step();
      drive_in(1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      check("mid_full", {31'd0, InReady}, 32'd0);
      #2;
      Reset = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, OutValid}, 32'd0);
      check("mid_rst_opa", OutOperandA, 32'd0);
      check("mid_rst_ready", {31'd0, InReady}, 32'd1);
      check("mid_rst_dest", {27'd0, OutDest}, 32'd0);
      step();
      Reset = 1'b0;
      step();
      check("post_rst_valid", {31'd0, OutValid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
